// File: rtl/tone_pkg.sv
// Shared constants and state type for the FFT peak-bin tracker.
package tone_pkg;

  localparam int NFFT_DEF   = 1024;
  localparam int DATA_W_DEF = 16;
  localparam int MAG_W_DEF  = 2*DATA_W_DEF + 1;

  typedef enum logic {
    SEARCH = 1'b0,
    RESYNC = 1'b1
  } peak_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: two-stage pipelined |X|^2 = re*re + im*im with an opaque
// sideband (bin index and frame tags) travelling alongside the valid tag.
module fft_mag_sq
  import tone_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAG_W  = MAG_W_DEF,
  parameter int SB_W   = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     vld_p0,
  input  logic signed [DATA_W-1:0] re_p0,
  input  logic signed [DATA_W-1:0] im_p0,
  input  logic [SB_W-1:0]          sb_p0,
  output logic                     vld_p2,
  output logic [MAG_W-1:0]         mag_p2,
  output logic [SB_W-1:0]          sb_p2
);

  logic                       vld_p1;
  logic signed [2*DATA_W-1:0] re_sq_p1;
  logic signed [2*DATA_W-1:0] im_sq_p1;
  logic [SB_W-1:0]            sb_p1;

  // Squares are never negative, so both terms zero-extend into the wider sum.
  function automatic logic [MAG_W-1:0] mag_sum(input logic signed [2*DATA_W-1:0] a,
                                               input logic signed [2*DATA_W-1:0] b);
    return MAG_W'($unsigned(a)) + MAG_W'($unsigned(b));
  endfunction

  // Stage p1: signed squares of both components.
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
    if (vld_p0) begin
      re_sq_p1 <= re_p0 * re_p0;
      im_sq_p1 <= im_p0 * im_p0;
      sb_p1    <= sb_p0;
    end
  end

  // Stage p2: unsigned magnitude-squared sum.
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
    if (vld_p1) begin
      mag_p2 <= mag_sum(re_sq_p1, im_sq_p1);
      sb_p2  <= sb_p1;
    end
  end

endmodule

// File: rtl/fft_peak_bin_tracker.sv
// fft_peak_bin_tracker: finds the strongest bin of each FFT frame and
// publishes (bin, |X|^2) through a one-entry output slot.
// Optional feature macro: PEAK_SILENCE_EN adds mag_thresh_in; a frame whose
// maximum is below the threshold (sampled at tlast) publishes bin 0 / mag 0.
module fft_peak_bin_tracker
  import tone_pkg::*;
#(
  parameter int  NFFT    = NFFT_DEF,
  parameter int  DATA_W  = DATA_W_DEF,
  parameter int  MIN_BIN = 2,
  parameter int  MAX_BIN = NFFT/2 - 1,
  localparam int BIN_W   = $clog2(NFFT),
  localparam int MAG_W   = 2*DATA_W + 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [2*DATA_W-1:0] fft_tdata,
  input  logic                fft_tvalid,
  input  logic                fft_tlast,
`ifdef PEAK_SILENCE_EN
  input  logic [MAG_W-1:0]    mag_thresh_in,
`endif
  output logic [BIN_W-1:0]    peak_bin,
  output logic [MAG_W-1:0]    peak_mag,
  output logic                peak_valid,
  input  logic                peak_ready,
  output logic                frame_err,
  output logic                overrun
);

  // Sideband layout: {bin, srch (compare allowed), pub (publish), clr (frame end)}
  localparam int SB_W = BIN_W + 3;

  peak_state_t      state;
  logic [BIN_W-1:0] cnt;
  logic             searching;
  logic             at_end;
  logic             srch_in;
  logic             pub_in;
  logic             clr_in;

  logic                     vld_p0;
  logic signed [DATA_W-1:0] re_p0;
  logic signed [DATA_W-1:0] im_p0;
  logic [SB_W-1:0]          sb_p0;

  logic             vld_p2;
  logic [MAG_W-1:0] mag_p2;
  logic [SB_W-1:0]  sb_p2;
  logic [BIN_W-1:0] bin_p2;
  logic             srch_p2;
  logic             pub_p2;
  logic             clr_p2;

  logic             have;
  logic [MAG_W-1:0] max_mag;
  logic [BIN_W-1:0] max_bin;
  logic             in_range;
  logic             upd;
  logic [MAG_W-1:0] nxt_mag;
  logic [BIN_W-1:0] nxt_bin;
  logic             silent;
  logic             pub_now;
  logic [BIN_W-1:0] res_bin;
  logic [MAG_W-1:0] res_mag;

  // Beat classification at the input, resolved against the current FSM state.
  // A beat at the last count without tlast is the overlong-frame error beat
  // and is excluded from the search.
  assign searching = (state == SEARCH);
  assign at_end    = (cnt == BIN_W'(NFFT - 1));
  assign pub_in    = searching && fft_tlast && at_end;
  assign clr_in    = fft_tlast || (searching && at_end);
  assign srch_in   = searching && (fft_tlast || !at_end);

  // Frame framing FSM: bin counter, SEARCH/RESYNC state, frame_err pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= SEARCH;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fft_tvalid) begin
        cnt <= fft_tlast ? '0 : cnt + BIN_W'(1);
        case (state)
          SEARCH: begin
            if (fft_tlast && !at_end) begin
              frame_err <= 1'b1;
            end else if (!fft_tlast && at_end) begin
              frame_err <= 1'b1;
              state     <= RESYNC;
            end
          end
          RESYNC: begin
            if (fft_tlast) state <= SEARCH;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Stage p0: register input components with bin index and frame tags.
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_p0 <= 1'b0;
    else        vld_p0 <= fft_tvalid;
    if (fft_tvalid) begin
      re_p0 <= fft_tdata[DATA_W-1:0];
      im_p0 <= fft_tdata[2*DATA_W-1:DATA_W];
      sb_p0 <= {cnt, srch_in, pub_in, clr_in};
    end
  end

  fft_mag_sq #(
    .DATA_W (DATA_W),
    .MAG_W  (MAG_W),
    .SB_W   (SB_W)
  ) u_mag (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .vld_p0 (vld_p0),
    .re_p0  (re_p0),
    .im_p0  (im_p0),
    .sb_p0  (sb_p0),
    .vld_p2 (vld_p2),
    .mag_p2 (mag_p2),
    .sb_p2  (sb_p2)
  );

  // Stage p2 output: running-max compare (strict, so ties keep the lowest bin).
  assign bin_p2   = sb_p2[SB_W-1:3];
  assign srch_p2  = sb_p2[2];
  assign pub_p2   = sb_p2[1];
  assign clr_p2   = sb_p2[0];
  assign in_range = (bin_p2 >= BIN_W'(MIN_BIN)) && (bin_p2 <= BIN_W'(MAX_BIN));
  assign upd      = vld_p2 && srch_p2 && in_range && (!have || (mag_p2 > max_mag));
  assign nxt_mag  = upd ? mag_p2 : max_mag;
  assign nxt_bin  = upd ? bin_p2 : max_bin;
  assign pub_now  = vld_p2 && pub_p2;

`ifdef PEAK_SILENCE_EN
  logic [MAG_W-1:0] thresh_q;

  // Threshold captured with the good tlast beat; the next one is a frame away.
  always_ff @(posedge clk_in) begin
    if (fft_tvalid && pub_in) thresh_q <= mag_thresh_in;
  end

  assign silent = (nxt_mag < thresh_q);
`else
  assign silent = 1'b0;
`endif

  assign res_bin = silent ? '0 : nxt_bin;
  assign res_mag = silent ? '0 : nxt_mag;

  // Running maximum: first in-range bin loads unconditionally, cleared at frame end.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      have    <= 1'b0;
      max_mag <= '0;
      max_bin <= '0;
    end else if (vld_p2) begin
      if (clr_p2) begin
        have    <= 1'b0;
        max_mag <= '0;
        max_bin <= '0;
      end else if (upd) begin
        have    <= 1'b1;
        max_mag <= mag_p2;
        max_bin <= bin_p2;
      end
    end
  end

  // Output slot: load when empty or drained this cycle, otherwise drop and flag overrun.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      peak_valid <= 1'b0;
      overrun    <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
    end else if (pub_now) begin
      if (!peak_valid || peak_ready) begin
        peak_valid <= 1'b1;
        peak_bin   <= res_bin;
        peak_mag   <= res_mag;
      end else begin
        overrun <= 1'b1;
      end
    end else if (peak_valid && peak_ready) begin
      peak_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_peak_bin_tracker.sv
// Testbench for fft_peak_bin_tracker: table-driven sparse frames, hand-written
// framing/backpressure/reset sequences and randomized frames against an
// argmax reference model. Silence checks only build with PEAK_SILENCE_EN.
module tb_fft_peak_bin_tracker;

  localparam int NFFT    = 1024;
  localparam int DATA_W  = 16;
  localparam int MIN_BIN = 2;
  localparam int MAX_BIN = 511;
  localparam int FR_LEN  = 1100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fft_tdata;
  logic        fft_tvalid;
  logic        fft_tlast;
  logic [9:0]  peak_bin;
  logic [32:0] peak_mag;
  logic        peak_valid;
  logic        peak_ready;
  logic        frame_err;
  logic        overrun;
`ifdef PEAK_SILENCE_EN
  logic [32:0] mag_thresh;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int err_beat;
  int lat;
  int eb;
  longint em;

  logic signed [15:0] fr_re [0:FR_LEN-1];
  logic signed [15:0] fr_im [0:FR_LEN-1];

  typedef struct {
    string  name;
    int     b0, r0, i0;
    int     b1, r1, i1;
    int     b2, r2, i2;
    int     exp_bin;
    longint exp_mag;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  fft_peak_bin_tracker #(
    .NFFT    (NFFT),
    .DATA_W  (DATA_W),
    .MIN_BIN (MIN_BIN),
    .MAX_BIN (MAX_BIN)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .fft_tdata     (fft_tdata),
    .fft_tvalid    (fft_tvalid),
    .fft_tlast     (fft_tlast),
`ifdef PEAK_SILENCE_EN
    .mag_thresh_in (mag_thresh),
`endif
    .peak_bin      (peak_bin),
    .peak_mag      (peak_mag),
    .peak_valid    (peak_valid),
    .peak_ready    (peak_ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name,
                              input int b0, input int r0, input int i0,
                              input int b1, input int r1, input int i1,
                              input int b2, input int r2, input int i2,
                              input int exp_bin, input longint exp_mag);
    vec_t v;
    v.name = name;
    v.b0 = b0; v.r0 = r0; v.i0 = i0;
    v.b1 = b1; v.r1 = r1; v.i1 = i1;
    v.b2 = b2; v.r2 = r2; v.i2 = i2;
    v.exp_bin = exp_bin;
    v.exp_mag = exp_mag;
    return v;
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < FR_LEN; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
  endtask

  task automatic set_bin(input int b, input int r, input int i);
    if (b >= 0) begin
      fr_re[b] = 16'(r);
      fr_im[b] = 16'(i);
    end
  endtask

  task automatic one_peak(input int b, input int r);
    clear_frame();
    set_bin(b, r, 0);
  endtask

  // Reference: argmax of |X|^2 over the searched bins, first (lowest) bin wins ties.
  task automatic model(output int bin, output longint mag);
    longint m;
    bin = MIN_BIN;
    mag = -1;
    for (int b = MIN_BIN; b <= MAX_BIN; b++) begin
      m = longint'(fr_re[b]) * longint'(fr_re[b]) + longint'(fr_im[b]) * longint'(fr_im[b]);
      if (m > mag) begin
        mag = m;
        bin = b;
      end
    end
`ifdef PEAK_SILENCE_EN
    if (mag < longint'(mag_thresh)) begin
      bin = 0;
      mag = 0;
    end
`endif
  endtask

  // Drives beats 0..n-1 from the frame arrays; returns one negedge after the last beat.
  task automatic send_frame(input int n, input bit last, input bit gaps);
    err_beat = -1;
    for (int k = 0; k < n; k++) begin
      if (gaps && ($urandom_range(0, 9) == 0)) begin
        fft_tvalid = 1'b0;
        fft_tlast  = 1'b0;
        @(negedge clk);
      end
      fft_tdata  = {fr_im[k], fr_re[k]};
      fft_tvalid = 1'b1;
      fft_tlast  = last && (k == n - 1);
      @(negedge clk);
      if (frame_err && (err_beat < 0)) err_beat = k;
    end
    fft_tvalid = 1'b0;
    fft_tlast  = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 1;
    while (!peak_valid && (l < 20)) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic consume();
    peak_ready = 1'b1;
    @(negedge clk);
    peak_ready = 1'b0;
    check("consume_clears_valid", peak_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    fft_tdata  = '0;
    fft_tvalid = 1'b0;
    fft_tlast  = 1'b0;
    peak_ready = 1'b0;
`ifdef PEAK_SILENCE_EN
    mag_thresh = '0;
`endif
    vecs[0] = mk("peak37",   37, 1000, 0,     -1, 0, 0,       -1, 0, 0,       37, 1000000);
    vecs[1] = mk("tie12_40", 12, 300, 400,    40, 300, 400,   1, 2000, 0,     12, 250000);
    vecs[2] = mk("edge511",  511, -32768, -32768, 512, 30000, 0, 3, 1, 0,     511, 64'd2147483648);
    vecs[3] = mk("edge2",    2, -5, 7,        0, 32000, 0,    1023, 0, 32000, 2, 74);
    vecs[4] = mk("allzero",  -1, 0, 0,        -1, 0, 0,       -1, 0, 0,       2, 0);
    vecs[5] = mk("neg300",   700, 30000, 0,   300, -1, -1,    2, 0, 1,        300, 2);

    repeat (3) @(negedge clk);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_bin", peak_bin, 0);
    check("rst_peak_mag", peak_mag, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sparse frames
    for (int v = 0; v < 6; v++) begin
      clear_frame();
      set_bin(vecs[v].b0, vecs[v].r0, vecs[v].i0);
      set_bin(vecs[v].b1, vecs[v].r1, vecs[v].i1);
      set_bin(vecs[v].b2, vecs[v].r2, vecs[v].i2);
      send_frame(NFFT, 1'b1, 1'b0);
      check({vecs[v].name, "_no_err"}, err_beat, -1);
      wait_valid(lat);
      check({vecs[v].name, "_latency"}, lat, 4);
      check({vecs[v].name, "_bin"}, peak_bin, vecs[v].exp_bin);
      check({vecs[v].name, "_mag"}, peak_mag, vecs[v].exp_mag);
      consume();
    end

    // Ready with nothing in the slot does nothing
    peak_ready = 1'b1;
    repeat (3) @(negedge clk);
    peak_ready = 1'b0;
    check("idle_ready_valid", peak_valid, 0);

    // Short frame: tlast on beat 500
    one_peak(200, 9000);
    send_frame(500, 1'b1, 1'b0);
    check("short_err_beat", err_beat, 499);
    @(negedge clk);
    check("short_err_pulse_width", frame_err, 0);
    repeat (6) @(negedge clk);
    check("short_no_result", peak_valid, 0);
    one_peak(9, 3000);
    send_frame(NFFT, 1'b1, 1'b0);
    wait_valid(lat);
    check("after_short_lat", lat, 4);
    check("after_short_bin", peak_bin, 9);
    check("after_short_mag", peak_mag, 9000000);
    consume();

    // Overlong frame: 1030 beats without tlast, then a tlast beat, then a clean frame
    clear_frame();
    set_bin(1024 + 5, 30000, 0);
    set_bin(300, 20000, 0);
    send_frame(1030, 1'b0, 1'b0);
    check("long_err_beat", err_beat, 1023);
    one_peak(0, 31000);
    set_bin(3, 31000, 0);
    send_frame(1, 1'b1, 1'b0);
    check("resync_tlast_no_err", err_beat, -1);
    repeat (8) @(negedge clk);
    check("resync_no_result", peak_valid, 0);
    one_peak(77, 20000);
    send_frame(NFFT, 1'b1, 1'b0);
    check("after_resync_no_err", err_beat, -1);
    wait_valid(lat);
    check("after_resync_bin", peak_bin, 77);
    check("after_resync_mag", peak_mag, 400000000);
    consume();

    // Randomized frames with input gaps against the reference model
    for (int f = 0; f < 5; f++) begin
      int a;
      int b;
      for (int k = 0; k < NFFT; k++) begin
        if (f % 2 == 0) begin
          fr_re[k] = 16'($urandom);
          fr_im[k] = 16'($urandom);
        end else begin
          fr_re[k] = 16'(int'($urandom_range(0, 200)) - 100);
          fr_im[k] = 16'(int'($urandom_range(0, 200)) - 100);
        end
      end
      if (f % 2 == 1) begin
        a = $urandom_range(MIN_BIN, 250);
        b = $urandom_range(251, MAX_BIN);
        set_bin(a, -32768, -32768);
        set_bin(b, -32768, -32768);
      end
      model(eb, em);
      send_frame(NFFT, 1'b1, 1'b1);
      wait_valid(lat);
      check("rand_lat", lat, 4);
      check("rand_bin", peak_bin, eb);
      check("rand_mag", peak_mag, em);
      consume();
    end

    // Backpressure: two results while not ready, then ready on the third result's cycle
    one_peak(20, 5000);
    send_frame(NFFT, 1'b1, 1'b0);
    wait_valid(lat);
    check("ovr_first_bin", peak_bin, 20);
    check("ovr_no_flag_yet", overrun, 0);
    one_peak(30, 6000);
    send_frame(NFFT, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("ovr_hold_bin", peak_bin, 20);
    check("ovr_hold_mag", peak_mag, 25000000);
    check("ovr_hold_valid", peak_valid, 1);
    check("ovr_flag", overrun, 1);
    one_peak(50, 7000);
    send_frame(NFFT, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("ovr_old_before_third", peak_bin, 20);
    peak_ready = 1'b1;
    @(negedge clk);
    peak_ready = 1'b0;
    check("ovr_third_bin", peak_bin, 50);
    check("ovr_third_mag", peak_mag, 49000000);
    check("ovr_third_valid", peak_valid, 1);
    check("ovr_flag_sticky", overrun, 1);

    // Reset in the middle of a frame
    one_peak(100, 30000);
    send_frame(600, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", peak_valid, 0);
    check("midrst_bin", peak_bin, 0);
    check("midrst_mag", peak_mag, 0);
    check("midrst_overrun", overrun, 0);
    repeat (8) @(negedge clk);
    check("midrst_no_result", peak_valid, 0);
    one_peak(45, 1234);
    send_frame(NFFT, 1'b1, 1'b0);
    check("midrst_next_no_err", err_beat, -1);
    wait_valid(lat);
    check("midrst_next_bin", peak_bin, 45);
    check("midrst_next_mag", peak_mag, 1522756);
    consume();

`ifdef PEAK_SILENCE_EN
    // Silence threshold: max 9997 below 10000 publishes zeros; exactly 10000 does not
    mag_thresh = 33'd10000;
    clear_frame();
    set_bin(60, 86, 51);
    send_frame(NFFT, 1'b1, 1'b0);
    wait_valid(lat);
    check("silence_valid", peak_valid, 1);
    check("silence_bin", peak_bin, 0);
    check("silence_mag", peak_mag, 0);
    consume();
    one_peak(60, 100);
    model(eb, em);
    send_frame(NFFT, 1'b1, 1'b0);
    wait_valid(lat);
    check("thresh_equal_bin", peak_bin, 60);
    check("thresh_equal_mag", peak_mag, 10000);
    check("thresh_model_bin", peak_bin, eb);
    consume();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
